mem_arbiter_2p: RTL and testbench

Two-port round-robin arbiter and sequencer in front of the single-port `Memory_16x32` array. It accepts independent read/write requests from two requesters, serialises them onto the memory's `Wr_En`/`Rd_En`/`Address`/`Data_in` bus, and waits for `Valid_out` on reads. It routes `Data_out` back to the owning requester, with a bounded wait and an error flag if the memory never responds.

---
 rtl/mem_arbiter_2p.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter_2p.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter/sequencer in front of a single-port memory array.
// Latency: grant 1 cycle after request sample; read data 3 cycles after sample; timeout Rd_Timeout+1 after grant.
// Backpressure: a requester holds ReqX until GntX; one operation outstanding at a time, others wait in IDLE.
//
// Ports:
//   CLK, Rst            clock, async active-high reset
//   ReqX/WrX/AddrX/WdataX  command from requester x (0,1), held until GntX
//   GntX                one-cycle pulse while x's command is on the memory bus
//   RdataX/RvalidX/RerrX   read completion for x; RerrX=1 marks a timed-out read
//   Busy                high while not IDLE
//   Mem_*               single-port memory bus (Wr_En, Rd_En, Address, Data_in, Data_out, Valid_out)
module mem_arbiter_2p #(
    parameter int Data_Width    = 32,
    parameter int Address_Width = 5,
    parameter int Rd_Timeout    = 4
) (
    input  logic                     CLK,
    input  logic                     Rst,
    input  logic                     Req0,
    input  logic                     Wr0,
    input  logic [Address_Width-1:0] Addr0,
    input  logic [Data_Width-1:0]    Wdata0,
    input  logic                     Req1,
    input  logic                     Wr1,
    input  logic [Address_Width-1:0] Addr1,
    input  logic [Data_Width-1:0]    Wdata1,
    output logic                     Gnt0,
    output logic                     Gnt1,
    output logic [Data_Width-1:0]    Rdata0,
    output logic [Data_Width-1:0]    Rdata1,
    output logic                     Rvalid0,
    output logic                     Rvalid1,
    output logic                     Rerr0,
    output logic                     Rerr1,
    output logic                     Busy,
    output logic                     Mem_Wr_En,
    output logic                     Mem_Rd_En,
    output logic [Address_Width-1:0] Mem_Addr,
    output logic [Data_Width-1:0]    Mem_Data_in,
    input  logic [Data_Width-1:0]    Mem_Data_out,
    input  logic                     Mem_Valid_out
);

    localparam int CW = (Rd_Timeout > 2) ? $clog2(Rd_Timeout) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_last;    // port served most recently
    logic            r_owner;   // port owning the operation in flight
    logic            r_wr;      // operation in flight is a write
    logic [CW-1:0]   r_cnt;     // cycles spent in WAIT

    logic            w_any;
    logic            w_pick1;

    assign w_any   = Req0 | Req1;
    // On a tie, the port not served last wins; otherwise the lone requester wins.
    assign w_pick1 = Req1 & (~Req0 | ~r_last);

    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_wr        <= 1'b0;
            r_cnt       <= '0;
            Gnt0        <= 1'b0;
            Gnt1        <= 1'b0;
            Rdata0      <= '0;
            Rdata1      <= '0;
            Rvalid0     <= 1'b0;
            Rvalid1     <= 1'b0;
            Rerr0       <= 1'b0;
            Rerr1       <= 1'b0;
            Busy        <= 1'b0;
            Mem_Wr_En   <= 1'b0;
            Mem_Rd_En   <= 1'b0;
            Mem_Addr    <= '0;
            Mem_Data_in <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            Gnt0      <= 1'b0;
            Gnt1      <= 1'b0;
            Rvalid0   <= 1'b0;
            Rvalid1   <= 1'b0;
            Rerr0     <= 1'b0;
            Rerr1     <= 1'b0;
            Mem_Wr_En <= 1'b0;
            Mem_Rd_En <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        // Latching straight into the memory-bus registers makes
                        // them valid for exactly the ISSUE cycle.
                        r_owner     <= w_pick1;
                        r_last      <= w_pick1;
                        r_wr        <= w_pick1 ? Wr1 : Wr0;
                        Mem_Addr    <= w_pick1 ? Addr1 : Addr0;
                        Mem_Data_in <= w_pick1 ? Wdata1 : Wdata0;
                        Mem_Wr_En   <= w_pick1 ? Wr1 : Wr0;
                        Mem_Rd_En   <= w_pick1 ? ~Wr1 : ~Wr0;
                        Gnt0        <= ~w_pick1;
                        Gnt1        <= w_pick1;
                        Busy        <= 1'b1;
                        r_state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_cnt <= '0;
                    if (r_wr) begin
                        Busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (Mem_Valid_out) begin
                        if (r_owner) begin
                            Rdata1  <= Mem_Data_out;
                            Rvalid1 <= 1'b1;
                        end else begin
                            Rdata0  <= Mem_Data_out;
                            Rvalid0 <= 1'b1;
                        end
                        Busy    <= 1'b0;
                        r_state <= IDLE;
                    end else if (r_cnt == CW'(Rd_Timeout - 1)) begin
                        // Memory never answered: complete with error and zero data.
                        if (r_owner) begin
                            Rdata1  <= '0;
                            Rvalid1 <= 1'b1;
                            Rerr1   <= 1'b1;
                        end else begin
                            Rdata0  <= '0;
                            Rvalid0 <= 1'b1;
                            Rerr0   <= 1'b1;
                        end
                        Busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    Busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
module tb_mem_arbiter_2p;

    logic        CLK;
    logic        Rst;
    logic        Req0, Wr0, Req1, Wr1;
    logic [4:0]  Addr0, Addr1;
    logic [31:0] Wdata0, Wdata1;
    logic        Gnt0, Gnt1, Rvalid0, Rvalid1, Rerr0, Rerr1, Busy;
    logic [31:0] Rdata0, Rdata1;
    logic        Mem_Wr_En, Mem_Rd_En;
    logic [4:0]  Mem_Addr;
    logic [31:0] Mem_Data_in, Mem_Data_out;
    logic        Mem_Valid_out;

    mem_arbiter_2p #(.Data_Width(32), .Address_Width(5), .Rd_Timeout(4)) dut (
        .CLK(CLK), .Rst(Rst),
        .Req0(Req0), .Wr0(Wr0), .Addr0(Addr0), .Wdata0(Wdata0),
        .Req1(Req1), .Wr1(Wr1), .Addr1(Addr1), .Wdata1(Wdata1),
        .Gnt0(Gnt0), .Gnt1(Gnt1),
        .Rdata0(Rdata0), .Rdata1(Rdata1),
        .Rvalid0(Rvalid0), .Rvalid1(Rvalid1),
        .Rerr0(Rerr0), .Rerr1(Rerr1),
        .Busy(Busy),
        .Mem_Wr_En(Mem_Wr_En), .Mem_Rd_En(Mem_Rd_En),
        .Mem_Addr(Mem_Addr), .Mem_Data_in(Mem_Data_in),
        .Mem_Data_out(Mem_Data_out), .Mem_Valid_out(Mem_Valid_out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: Valid_out the cycle after the Rd_En cycle.
    logic [31:0] mem [32];
    logic        mv_q = 1'b0;
    logic        hold_low = 1'b0;
    logic        inj = 1'b0;
    always @(posedge CLK) begin
        if (Mem_Wr_En) mem[Mem_Addr] <= Mem_Data_in;
        if (Mem_Rd_En) Mem_Data_out <= mem[Mem_Addr];
        mv_q <= Mem_Rd_En & ~hold_low;
    end
    assign Mem_Valid_out = mv_q | inj;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_pass = 0;
    int n_total = 0;
    int spurious = 0;
    int overlap = 0;

    typedef struct {
        int          port;
        logic [31:0] data;
        logic        err;
        int          lat;
        int          t0;
    } exp_t;
    exp_t sb[$];
    int   gnt_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Scoreboard side: pop expectations when the DUT completes a read.
    always @(negedge CLK) begin
        if (!Rst) begin
            if (Gnt0 && Gnt1) overlap++;
            if (Rvalid0 && Rvalid1) overlap++;
            if (Gnt0) gnt_log.push_back(0);
            if (Gnt1) gnt_log.push_back(1);
            if (Rvalid0 || Rvalid1) begin
                if (sb.size() == 0) begin
                    spurious++;
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("rv_port", Rvalid1 ? 32'd1 : 32'd0, e.port);
                    chk("rv_data", Rvalid1 ? Rdata1 : Rdata0, e.data);
                    chk("rv_err", Rvalid1 ? Rerr1 : Rerr0, e.err);
                    chk("rv_latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic wait_sb(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_flags"}, {Gnt0, Gnt1, Rvalid0, Rvalid1, Rerr0, Rerr1, Busy, Mem_Wr_En, Mem_Rd_En}, 0);
        chk({nm, "_rdata0"}, Rdata0, 0);
        chk({nm, "_rdata1"}, Rdata1, 0);
        chk({nm, "_mem_addr"}, Mem_Addr, 0);
        chk({nm, "_mem_din"}, Mem_Data_in, 0);
    endtask

    task automatic wait_gnt(input int p, input string nm);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!(p == 0 ? Gnt0 : Gnt1) && n < 20);
        chk(nm, (p == 0 ? Gnt0 : Gnt1), 1);
    endtask

    // One isolated command from an idle DUT.
    task automatic issue(input int p, input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat);
        int w = 0;
        @(negedge CLK);
        if (p == 0) begin Req0 = 1; Wr0 = wr; Addr0 = a; Wdata0 = d; end
        else        begin Req1 = 1; Wr1 = wr; Addr1 = a; Wdata1 = d; end
        if (!wr) sb.push_back('{p, exp_d, exp_e, exp_lat, cyc});
        do begin
            @(negedge CLK);
            w++;
        end while (!(p == 0 ? Gnt0 : Gnt1) && w < 20);
        chk("gnt_latency", w, 1);
        chk("gnt_mem_en", {Mem_Wr_En, Mem_Rd_En}, wr ? 2'b10 : 2'b01);
        chk("gnt_mem_addr", Mem_Addr, a);
        if (wr) chk("gnt_mem_data", Mem_Data_in, d);
        if (p == 0) Req0 = 0; else Req1 = 0;
        wait_sb(20);
    endtask

    typedef struct {
        int          port;
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0, 1'b1, 5'd5,  32'hDEADBEEF, 32'h0};
        tbl[1] = '{0, 1'b0, 5'd5,  32'h0,        32'hDEADBEEF};
        tbl[2] = '{1, 1'b1, 5'd9,  32'h12345678, 32'h0};
        tbl[3] = '{1, 1'b0, 5'd9,  32'h0,        32'h12345678};
        tbl[4] = '{0, 1'b1, 5'd31, 32'hFFFFFFFF, 32'h0};
        tbl[5] = '{1, 1'b0, 5'd31, 32'h0,        32'hFFFFFFFF};
        tbl[6] = '{0, 1'b0, 5'd9,  32'h0,        32'h12345678};
        tbl[7] = '{1, 1'b1, 5'd0,  32'hA5A5A5A5, 32'h0};
        tbl[8] = '{0, 1'b0, 5'd0,  32'h0,        32'hA5A5A5A5};

        // Reset with garbage on inputs.
        Rst = 0;
        Req0 = 1; Wr0 = 1; Addr0 = 5'h1F; Wdata0 = 32'hCAFEF00D;
        Req1 = 1; Wr1 = 0; Addr1 = 5'h0A; Wdata1 = 32'h55AA55AA;
        #3 Rst = 1;
        #1 chk_zero("rst_async");
        @(posedge CLK);
        #1 chk_zero("rst_held");
        @(negedge CLK);
        Req0 = 0; Req1 = 0; Wr0 = 0; Wr1 = 0;
        Addr0 = 0; Addr1 = 0; Wdata0 = 0; Wdata1 = 0;
        Rst = 0;
        repeat (3) @(negedge CLK);
        chk("idle_after_rst_busy", Busy, 0);

        // Table-driven single commands.
        for (int i = 0; i < 9; i++)
            issue(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rdata, 1'b0, 3);

        // Read timeout on port 1; port 0's data must hold.
        hold_low = 1;
        issue(1, 1'b0, 5'd7, 32'h0, 32'h0, 1'b1, 6);
        hold_low = 0;
        chk("rdata0_hold", Rdata0, 32'hA5A5A5A5);
        @(negedge CLK); inj = 1;
        @(negedge CLK); inj = 0;
        repeat (2) @(negedge CLK);
        chk("late_valid_busy", Busy, 0);

        // Tie and fairness: both ports write continuously.
        @(negedge CLK);
        gnt_log.delete();
        Req0 = 1; Wr0 = 1; Addr0 = 5'd1; Wdata0 = 32'h11111111;
        Req1 = 1; Wr1 = 1; Addr1 = 5'd2; Wdata1 = 32'h22222222;
        repeat (8) @(negedge CLK);
        Req0 = 0; Req1 = 0;
        chk("tie_gnt_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            chk($sformatf("tie_gnt_order%0d", i), gnt_log[i], i % 2);
        repeat (2) @(negedge CLK);
        issue(1, 1'b0, 5'd1, 32'h0, 32'h11111111, 1'b0, 3);
        issue(0, 1'b0, 5'd2, 32'h0, 32'h22222222, 1'b0, 3);

        // Reset during WAIT: no completion, then port 0 wins the first tie.
        @(negedge CLK);
        Req0 = 1; Wr0 = 0; Addr0 = 5'd5;
        wait_gnt(0, "midrd_gnt0");
        Req0 = 0;
        @(negedge CLK);
        chk("midrd_wait_busy", Busy, 1);
        #2 Rst = 1;
        #1 chk_zero("midrd_rst");
        @(negedge CLK);
        @(negedge CLK);
        Rst = 0;
        Req0 = 1; Wr0 = 0; Addr0 = 5'd5;
        Req1 = 1; Wr1 = 0; Addr1 = 5'd9;
        sb.push_back('{0, 32'hDEADBEEF, 1'b0, 3, cyc});
        sb.push_back('{1, 32'h12345678, 1'b0, 6, cyc});
        begin
            int n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!(Gnt0 || Gnt1) && n < 20);
        end
        chk("post_rst_tie_gnt0", Gnt0, 1);
        chk("post_rst_tie_gnt1", Gnt1, 0);
        Req0 = 0;
        wait_gnt(1, "post_rst_tie_second_gnt1");
        Req1 = 0;
        wait_sb(20);

        // Request dropped right after being sampled still completes.
        @(negedge CLK);
        Req1 = 1; Wr1 = 0; Addr1 = 5'd31;
        sb.push_back('{1, 32'hFFFFFFFF, 1'b0, 3, cyc});
        @(posedge CLK);
        #1 Req1 = 0;
        @(negedge CLK);
        chk("drop_gnt1", Gnt1, 1);
        wait_sb(20);

        repeat (3) @(negedge CLK);
        chk("spurious_rvalid", spurious, 0);
        chk("gnt_rvalid_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
